// File: rtl/rv_arch_state.sv
// Architectural state of the single-cycle RV32 core: PC register, 2R/1W register
// file with x0 hardwired to zero, and a key/value lookup mux with a default output.
module rv_arch_state #(
    parameter int              ADDR_WIDTH = 5,
    parameter int              DATA_WIDTH = 32,
    parameter logic [31:0]     RESET_PC   = 32'h8000_0000,
    parameter int              NR_KEY     = 8,
    parameter int              KEY_LEN    = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pc_wen,
    input  logic [DATA_WIDTH-1:0]                dpc,
    output logic [DATA_WIDTH-1:0]                pc,
    input  logic [ADDR_WIDTH-1:0]                rs1addr,
    input  logic [ADDR_WIDTH-1:0]                rs2addr,
    output logic [DATA_WIDTH-1:0]                rs1data,
    output logic [DATA_WIDTH-1:0]                rs2data,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic                                 wen,
    input  logic [KEY_LEN-1:0]                   mux_key,
    input  logic [DATA_WIDTH-1:0]                mux_default,
    input  logic [NR_KEY*(KEY_LEN+DATA_WIDTH)-1:0] mux_lut,
    output logic [DATA_WIDTH-1:0]                mux_out
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int PAIR_W = KEY_LEN + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg <= DATA_WIDTH'(RESET_PC);
        end else if (pc_wen) begin
            pc_reg <= dpc;
        end
    end

    assign pc = pc_reg;

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    assign rs1data = (rs1addr == '0) ? '0 : regs_reg[rs1addr];
    assign rs2data = (rs2addr == '0) ? '0 : regs_reg[rs2addr];

    logic [NR_KEY-1:0]     hit;
    logic [DATA_WIDTH-1:0] masked [NR_KEY];

    genvar gi;
    generate
        for (gi = 0; gi < NR_KEY; gi++) begin : g_pair
            logic [KEY_LEN-1:0]    pair_key;
            logic [DATA_WIDTH-1:0] pair_data;
            assign pair_key   = mux_lut[gi*PAIR_W + DATA_WIDTH +: KEY_LEN];
            assign pair_data  = mux_lut[gi*PAIR_W +: DATA_WIDTH];
            assign hit[gi]    = (pair_key == mux_key);
            assign masked[gi] = hit[gi] ? pair_data : '0;
        end
    endgenerate

    // Multiple matches merge by OR; the default only applies when nothing hits.
    logic [DATA_WIDTH-1:0] or_next;

    always_comb begin
        or_next = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            or_next = or_next | masked[i];
        end
        mux_out = (hit != '0) ? or_next : mux_default;
    end

endmodule

// File: tb/tb_rv_arch_state.sv
// Directed self-checking bench for rv_arch_state: reset, PC, register file, lookup mux.
module tb_rv_arch_state;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NR_KEY     = 8;
    localparam int KEY_LEN    = 7;
    localparam int P          = KEY_LEN + DATA_WIDTH;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         pc_wen;
    logic [DATA_WIDTH-1:0]        dpc;
    logic [DATA_WIDTH-1:0]        pc;
    logic [ADDR_WIDTH-1:0]        rs1addr, rs2addr, waddr;
    logic [DATA_WIDTH-1:0]        rs1data, rs2data, wdata;
    logic                         wen;
    logic [KEY_LEN-1:0]           mux_key;
    logic [DATA_WIDTH-1:0]        mux_default;
    logic [NR_KEY*P-1:0]          mux_lut;
    logic [DATA_WIDTH-1:0]        mux_out;

    int tests = 0;
    int fails = 0;

    rv_arch_state #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .RESET_PC  (RESET_PC),
        .NR_KEY    (NR_KEY),
        .KEY_LEN   (KEY_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_wen     (pc_wen),
        .dpc        (dpc),
        .pc         (pc),
        .rs1addr    (rs1addr),
        .rs2addr    (rs2addr),
        .rs1data    (rs1data),
        .rs2data    (rs2data),
        .waddr      (waddr),
        .wdata      (wdata),
        .wen        (wen),
        .mux_key    (mux_key),
        .mux_default(mux_default),
        .mux_lut    (mux_lut),
        .mux_out    (mux_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i < 32; i++) begin
            rs1addr = 5'(i);
            rs2addr = 5'(31 - i + 1);
            #1;
            check({tag, "_rs1"}, rs1data, 32'h0);
            check({tag, "_rs2"}, rs2data, 32'h0);
        end
    endtask

    // Pairs 2..7 get keys 0x42..0x47 with data 0xC0DE_00xx so they never collide.
    task automatic fill_lut();
        mux_lut = '0;
        for (int i = 2; i < NR_KEY; i++) begin
            mux_lut[i*P +: P] = {7'(7'h40 + i), 32'hC0DE_0000 + 32'(i)};
        end
    endtask

    initial begin
        rst = 1'b0; pc_wen = 1'b0; dpc = '0; wen = 1'b0;
        rs1addr = '0; rs2addr = '0; waddr = '0; wdata = '0;
        mux_key = 7'h7F; mux_default = 32'hFFFF_FFFF;
        fill_lut();

        // 1. Reset and PC load
        tick(); tick();
        check("reset_pc", pc, RESET_PC);
        check_all_zero("reset_regs");

        rst = 1'b1; pc_wen = 1'b1; dpc = 32'h8000_0004;
        tick();
        check("pc_load", pc, 32'h8000_0004);
        pc_wen = 1'b0; dpc = 32'h1234_5678;
        tick();
        check("pc_hold", pc, 32'h8000_0004);

        // 2. Register write/read and x0
        write_reg(5'd5, 32'hDEAD_BEEF);
        rs1addr = 5'd5; #1;
        check("rd_x5", rs1data, 32'hDEAD_BEEF);
        write_reg(5'd0, 32'h1234_5678);
        rs2addr = 5'd0; #1;
        check("rd_x0", rs2data, 32'h0);
        wen = 1'b0; waddr = 5'd5; wdata = 32'h1;
        tick();
        rs1addr = 5'd5; rs2addr = 5'd5; #1;
        check("wen0_rs1", rs1data, 32'hDEAD_BEEF);
        check("wen0_rs2", rs2data, 32'hDEAD_BEEF);

        // 3. Read-during-write
        write_reg(5'd7, 32'h11);
        rs1addr = 5'd7; wen = 1'b1; waddr = 5'd7; wdata = 32'h22;
        #1;
        check("rdw_before", rs1data, 32'h11);
        tick();
        wen = 1'b0;
        check("rdw_after", rs1data, 32'h22);

        // 4. Lookup mux hit/miss
        fill_lut();
        mux_lut[2*P-1:0] = {7'h13, 32'hAAAA_0000, 7'h6F, 32'h0000_5555};
        mux_default = 32'hFFFF_FFFF;
        mux_key = 7'h13; #1;
        check("mux_hit_p1", mux_out, 32'hAAAA_0000);
        mux_key = 7'h6F; #1;
        check("mux_hit_p0", mux_out, 32'h0000_5555);
        mux_key = 7'h33; #1;
        check("mux_miss", mux_out, 32'hFFFF_FFFF);
        mux_key = 7'h47; #1;
        check("mux_hit_p7", mux_out, 32'hC0DE_0007);
        mux_default = 32'h0BAD_F00D; mux_key = 7'h00; #1;
        check("mux_miss_def2", mux_out, 32'h0BAD_F00D);

        // 5. Duplicate keys OR together, default excluded
        mux_lut[2*P-1:0] = {7'h03, 32'h0F0F_0000, 7'h03, 32'h0000_00F0};
        mux_key = 7'h03; #1;
        check("mux_dup", mux_out, 32'h0F0F_00F0);

        // 6. Mid-operation reset beats concurrent write and PC load
        write_reg(5'd1, 32'h0000_0111);
        write_reg(5'd2, 32'h0000_0222);
        write_reg(5'd3, 32'h0000_0333);
        pc_wen = 1'b1; dpc = 32'h0000_1000;
        tick();
        pc_wen = 1'b0;
        check("pc_adv", pc, 32'h0000_1000);
        rs1addr = 5'd2; rs2addr = 5'd3; #1;
        check("pre_rst_x2", rs1data, 32'h0000_0222);
        check("pre_rst_x3", rs2data, 32'h0000_0333);
        rst = 1'b0; wen = 1'b1; waddr = 5'd2; wdata = 32'hFFFF_0000;
        pc_wen = 1'b1; dpc = 32'h0000_2000;
        tick();
        rst = 1'b1; wen = 1'b0; pc_wen = 1'b0;
        check("midrst_pc", pc, RESET_PC);
        check_all_zero("midrst_regs");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
